mine_placer: RTL and testbench
==============================

// Module: mine_placer
// PURPOSE
//  Consumer end of the game_set_if settings handshake driven by the level-selection block.
//  Captures the board geometry (button_num) when a level is chosen and fills a 16x16
//  mine bitmap with the level's mine count, using LFSR rejection sampling.
//  Serves per-cell mine queries to the board/draw logic.
//  Raises board_ready once the mine layout is complete.
// PARAMETERS
//  LFSR_SEED   16'hACE1  non-zero reset seed of the free-running 16-bit LFSR
//  MAX_BTN     16        max buttons per row/column; the bitmap is MAX_BTN x MAX_BTN
// PORTS
//  clk            in   1    system clock
//  rst            in   1    reset, synchronous, active-high
//  level_enable   in   1    level-select strobe from the level-selection block
//  in             in   if   game_set_if.in; only button_num[4:0] is consumed
//  clear          in   1    return to IDLE and wipe the bitmap (new game)
//  query_x        in   4    column of the queried cell
//  query_y        in   4    row of the queried cell
//  query_mine     out  1    1 = mine at (query_x,query_y); valid 1 cycle after query
//  mines_placed   out  6    count of mines placed so far
//  busy           out  1    high while in PLACE
//  board_ready    out  1    high while in READY (level, not pulse)
// BEHAVIOUR
//  - Reset: state=IDLE, bitmap all 0, btn_num_q=0, target_q=0, mines_placed=0,
//    busy=0, board_ready=0, query_mine=0, LFSR=LFSR_SEED.
//  - Settings are valid only in a cycle with level_enable=1 AND in.button_num!=0.
//    Capture happens in that cycle only. level_enable high with button_num=0 is ignored.
//  - Target lookup on capture: button_num 8->8 mines, 10->20, 16->50, any other->0.
//  - FSM:
//    IDLE  --valid capture--> PLACE (target!=0) or READY (target==0, empty map)
//    PLACE --mines_placed==target--> READY
//    READY stays in READY; further level_enable strobes are ignored.
//    any   --clear--> IDLE; next edge: bitmap=0, mines_placed=0.
//    clear has priority over capture and placement in the same cycle.
//  - Placement, one candidate per PLACE cycle:
//    cx = lfsr[3:0], cy = lfsr[7:4].
//    Accept iff cx<btn_num_q AND cy<btn_num_q AND map[cy][cx]==0.
//    On accept, the next edge sets map[cy][cx] and increments mines_placed.
//    The LFSR steps every cycle in all states (entropy from idle time).
//    Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form; all-zero never reached.
//  - Completion: the exit test uses the registered count. board_ready rises in the
//    cycle after the final mine's bitmap write is visible.
//  - Placement latency is unbounded but finite: the LFSR covers every (cx,cy).
//    Typical run is under 200 cycles for the 16x16/50 case.
//  - Arithmetic: mines_placed is 6 bits; max target 50 < 64, so no wrap.
//    Candidate compares are 5-bit unsigned against btn_num_q.
//  - Query path: query_mine <= map[query_y][query_x] when both coordinates < btn_num_q.
//    Otherwise query_mine <= 0, including in IDLE and on a cleared map.
//    The query returns the bitmap state as of the previous edge, including partial
//    maps during PLACE.
//  - Reset mid-PLACE: full return to reset values; no partial map survives.
// STRUCTURE
//  - game_pkg: MINES_L1=8, MINES_L2=20, MINES_L3=50, BTN_L1=8, BTN_L2=10, BTN_L3=16,
//    and the placer_state_t enum {IDLE, PLACE, READY}.
//  - Sub-module lfsr16 (clk, rst, seed param, 16-bit state out), reusable elsewhere.
//  - Bitmap is a logic [15:0][15:0] register array; no RAM inference needed.
// TESTING
//  1. Reset, then level_enable=1 for 2 cycles with button_num 0 then 8
//     -> capture in 2nd cycle, busy=1 next cycle; board_ready=1 with mines_placed=8;
//     popcount(map)=8; all mines in x,y<8.
//  2. button_num=16 -> mines_placed=50 at READY, no duplicate cells,
//     query of every cell sums to 50.
//  3. button_num=10, query (12,3) -> query_mine=0.
//     Query a known mine cell -> query_mine=1 exactly one cycle later.
//  4. Assert clear in the middle of PLACE (mines_placed=5)
//     -> IDLE next cycle, map=0, mines_placed=0.
//     clear together with a valid capture -> stays IDLE.
//  5. In READY, pulse level_enable with button_num=16 -> ignored; map and count unchanged.
//     button_num=12 from IDLE -> READY next cycle with 0 mines.
//  6. Assert rst during PLACE -> all outputs at reset values next cycle;
//     LFSR restarts at LFSR_SEED; repeat of test 1 gives an identical map (determinism).

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: level geometry/mine-count constants and placer state encoding shared by the
// level-selection and board blocks.
package game_pkg;
    localparam logic [5:0] MINES_L1 = 6'd8;
    localparam logic [5:0] MINES_L2 = 6'd20;
    localparam logic [5:0] MINES_L3 = 6'd50;
    localparam logic [4:0] BTN_L1   = 5'd8;
    localparam logic [4:0] BTN_L2   = 5'd10;
    localparam logic [4:0] BTN_L3   = 5'd16;
    typedef enum logic [1:0] {IDLE, PLACE, READY} placer_state_t;
    function automatic logic [5:0] mines_for(input logic [4:0] b);
        return (b == BTN_L1) ? MINES_L1 : (b == BTN_L2) ? MINES_L2 : (b == BTN_L3) ? MINES_L3 : 6'd0;
    endfunction
endpackage

// File: rtl/game_set_if.sv
// game_set_if: game settings handshake from level selection (master) to board blocks (slave).
interface game_set_if;
    logic [4:0] button_num;
    modport master (output button_num);
    modport slave  (input  button_num);
endinterface

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, low OUT_W bits exposed.
module lfsr16 #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] state
);
    logic [15:0] r_state;
    always_ff @(posedge clk)
        r_state <= rst ? SEED : {r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5], r_state[15:1]};
    assign state = r_state[OUT_W-1:0];
endmodule

// File: rtl/mine_placer.sv
// mine_placer: captures level geometry, fills the mine bitmap by LFSR rejection sampling,
// and answers per-cell mine queries one cycle later.
module mine_placer
    import game_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_BTN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_enable,
    game_set_if.slave  in,
    input  logic       clear,
    input  logic [3:0] query_x,
    input  logic [3:0] query_y,
    output logic       query_mine,
    output logic [5:0] mines_placed,
    output logic       busy,
    output logic       board_ready
);
    placer_state_t                   r_state, w_next;
    logic [MAX_BTN-1:0][MAX_BTN-1:0] r_map;
    logic [4:0]                      r_btn;
    logic [5:0]                      r_target, r_count, w_target;
    logic [7:0]                      w_lfsr;
    logic                            r_query, w_capture, w_accept;

    lfsr16 #(.SEED(LFSR_SEED), .OUT_W(8)) u_lfsr (.clk(clk), .rst(rst), .state(w_lfsr));

    assign w_capture = level_enable && in.button_num != 5'd0;
    assign w_target  = mines_for(in.button_num);
    // candidate (cx,cy) = (lfsr[3:0], lfsr[7:4]); rejected if off-board or already mined
    assign w_accept  = r_state == PLACE && !clear && r_count != r_target
                       && {1'b0, w_lfsr[3:0]} < r_btn && {1'b0, w_lfsr[7:4]} < r_btn
                       && !r_map[w_lfsr[7:4]][w_lfsr[3:0]];

    always_comb begin
        w_next = r_state;
        if (clear)
            w_next = IDLE;
        else if (r_state == IDLE && w_capture)
            w_next = (w_target != 6'd0) ? PLACE : READY;
        else if (r_state == PLACE && r_count == r_target)
            w_next = READY;
    end

    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_map    <= '0;
            r_count  <= 6'd0;
            r_btn    <= 5'd0;
            r_target <= 6'd0;
        end else begin
            if (r_state == IDLE && w_capture) begin
                r_btn    <= in.button_num;
                r_target <= w_target;
            end
            if (w_accept) begin
                r_map[w_lfsr[7:4]][w_lfsr[3:0]] <= 1'b1;
                r_count                         <= r_count + 6'd1;
            end
        end
    end

    always_ff @(posedge clk)
        r_query <= rst ? 1'b0 : ({1'b0, query_x} < r_btn && {1'b0, query_y} < r_btn) ? r_map[query_y][query_x] : 1'b0;

    assign query_mine   = r_query;
    assign mines_placed = r_count;
    assign busy         = r_state == PLACE;
    assign board_ready  = r_state == READY;
endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: scoreboard bench; a list-based placement model predicts map, count and latency.
module tb_mine_placer;
    logic       clk = 1'b0, rst = 1'b1, level_enable = 1'b0, clear = 1'b0;
    logic [3:0] qx = 4'd0, qy = 4'd0;
    logic       query_mine, busy, board_ready;
    logic [5:0] mines_placed;
    game_set_if gs();

    mine_placer dut (
        .clk(clk), .rst(rst), .level_enable(level_enable), .in(gs), .clear(clear),
        .query_x(qx), .query_y(qy), .query_mine(query_mine),
        .mines_placed(mines_placed), .busy(busy), .board_ready(board_ready)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; bit exp;} q_t;
    q_t          sb[$];
    int          checks = 0, errors = 0, q_sum = 0, m_btn = 0;
    bit          qv = 1'b0, qv_d = 1'b0;
    bit          m_map[16][16];
    bit          map1[16][16];
    logic [15:0] lfsr_m;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {^(s & 16'h002D), s[15:1]};
    endfunction

    always @(posedge clk) lfsr_m <= rst ? 16'hACE1 : step(lfsr_m);
    always @(posedge clk) qv_d <= qv;

    always @(negedge clk) begin
        q_t e;
        if (qv_d) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL query_sb_empty got %0b", query_mine);
            end else begin
                e = sb.pop_front();
                q_sum += int'(query_mine);
                if (query_mine !== e.exp) begin
                    errors++;
                    $display("FAIL query(%0d,%0d) got %0b want %0b", e.x, e.y, query_mine, e.exp);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        m_btn = 0;
        foreach (m_map[y, x]) m_map[y][x] = 1'b0;
    endtask

    task automatic start(input int btn, input int gap, output int n);
        int tgt, cnt, cx, cy;
        logic [15:0] s;
        repeat (gap) tick;
        level_enable = 1'b1;
        gs.button_num = 5'(btn);
        tick;
        level_enable = 1'b0;
        tgt = (btn == 8) ? 8 : (btn == 10) ? 20 : (btn == 16) ? 50 : 0;
        clear_model();
        m_btn = btn;
        chk("busy_after_capture", busy, tgt != 0);
        chk("ready_after_capture", board_ready, tgt == 0);
        s = lfsr_m;
        cnt = 0;
        n = 0;
        while (cnt < tgt && n < 100000) begin
            cx = int'(s[3:0]);
            cy = int'(s[7:4]);
            if (cx < btn && cy < btn && !m_map[cy][cx]) begin
                m_map[cy][cx] = 1'b1;
                cnt++;
            end
            s = step(s);
            n++;
        end
    endtask

    task automatic finish_place(input int n, input int tgt);
        int k = 0;
        while (!board_ready && k < 5000) begin
            tick;
            k++;
        end
        chk("ready_latency", k, n + 1);
        chk("mines_at_ready", mines_placed, tgt);
        chk("busy_at_ready", busy, 0);
    endtask

    task automatic sweep;
        q_sum = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                qx = 4'(x);
                qy = 4'(y);
                sb.push_back('{x, y, (x < m_btn && y < m_btn) ? m_map[y][x] : 1'b0});
                qv = 1'b1;
                tick;
            end
        qv = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        clear_model();
        chk("clear_busy", busy, 0);
        chk("clear_ready", board_ready, 0);
        chk("clear_mines", mines_placed, 0);
    endtask

    task automatic test1_seq;
        int n;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        clear_model();
        chk("rst_busy", busy, 0);
        chk("rst_ready", board_ready, 0);
        chk("rst_mines", mines_placed, 0);
        chk("rst_query", query_mine, 0);
        level_enable = 1'b1;
        gs.button_num = 5'd0;
        tick;
        chk("btn0_ignored_busy", busy, 0);
        chk("btn0_ignored_ready", board_ready, 0);
        start(8, 0, n);
        finish_place(n, 8);
        sweep();
        chk("sum_8x8", q_sum, 8);
    endtask

    initial begin
        int n, k;
        gs.button_num = 5'd0;
        test1_seq();
        foreach (map1[y, x]) map1[y][x] = m_map[y][x];

        do_clear();
        start(16, $urandom_range(0, 9), n);
        finish_place(n, 50);
        sweep();
        chk("sum_16x16", q_sum, 50);

        do_clear();
        start(10, $urandom_range(0, 9), n);
        finish_place(n, 20);
        sweep();
        chk("sum_10x10", q_sum, 20);
        for (int i = 0; i < 40; i++) begin
            qx = 4'($urandom_range(0, 15));
            qy = 4'($urandom_range(0, 15));
            sb.push_back('{int'(qx), int'(qy), (qx < 10 && qy < 10) ? m_map[qy][qx] : 1'b0});
            qv = 1'b1;
            tick;
        end
        qv = 1'b0;
        @(negedge clk);
        #1;

        do_clear();
        start(16, $urandom_range(0, 9), n);
        k = 0;
        while (mines_placed != 6'd5 && k < 500) begin
            tick;
            k++;
        end
        chk("mid_place_count", mines_placed, 5);
        chk("mid_place_busy", busy, 1);
        do_clear();
        clear = 1'b1;
        level_enable = 1'b1;
        gs.button_num = 5'd8;
        tick;
        clear = 1'b0;
        level_enable = 1'b0;
        chk("clear_cap_busy", busy, 0);
        chk("clear_cap_ready", board_ready, 0);
        tick;
        chk("clear_cap_idle", busy | board_ready, 0);

        start(16, $urandom_range(0, 9), n);
        finish_place(n, 50);
        level_enable = 1'b1;
        gs.button_num = 5'd16;
        tick;
        level_enable = 1'b0;
        chk("ready_strobe_ready", board_ready, 1);
        chk("ready_strobe_busy", busy, 0);
        chk("ready_strobe_mines", mines_placed, 50);
        sweep();
        chk("ready_strobe_sum", q_sum, 50);

        do_clear();
        start(12, $urandom_range(0, 9), n);
        chk("btn12_mines", mines_placed, 0);
        sweep();
        chk("btn12_sum", q_sum, 0);

        do_clear();
        start(16, $urandom_range(0, 9), n);
        repeat (10) tick;
        chk("pre_rst_busy", busy, 1);
        test1_seq();
        foreach (m_map[y, x]) m_map[y][x] = map1[y][x];
        sweep();
        chk("determinism_sum", q_sum, 8);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
